// File: rtl/stage_phase_accumulation_fb.sv
// stage_phase_accumulation_fb: per-operator phase accumulator with modulation, self-feedback and key-on reset
module stage_phase_accumulation_fb #(
   parameter int NUM_OPERATORS = 32,
   parameter int ACC_WIDTH     = 24,
   parameter int PHASE_WIDTH   = 16,
   parameter int ALG_WIDTH     = 8,
   localparam int OP_W         = $clog2(NUM_OPERATORS)
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset_n,
   input  logic                   i_Valid,
   input  logic [OP_W-1:0]        i_VoiceOperator,
   input  logic [ALG_WIDTH-1:0]   i_AlgorithmWord,
   input  logic [PHASE_WIDTH-1:0] i_ModulationPhase,
   input  logic                   i_KeyOn,
   output logic                   o_Ready,
   output logic                   o_Valid,
   output logic [OP_W-1:0]        o_VoiceOperator,
   output logic [ALG_WIDTH-1:0]   o_AlgorithmWord,
   output logic [PHASE_WIDTH:0]   o_ModulatedPhase,
   input  logic                   i_FeedbackValid,
   input  logic [OP_W-1:0]        i_FeedbackOperator,
   input  logic [PHASE_WIDTH-1:0] i_FeedbackSample,
   input  logic                   i_ConfigWriteEnable,
   input  logic [OP_W-1:0]        i_ConfigWriteAddr,
   input  logic [2:0]             i_ConfigWriteSel,
   input  logic [7:0]             i_ConfigWriteData
);
   localparam int NB = ACC_WIDTH / 8;
   localparam int PW = PHASE_WIDTH;

   typedef enum logic {CLEAR, RUN} state_t;
   state_t state, state_next;
   logic [OP_W-1:0] clr_cnt;
   logic run, clr_en;

   logic [ACC_WIDTH-1:0] acc_mem  [NUM_OPERATORS];
   logic [ACC_WIDTH-1:0] step_mem [NUM_OPERATORS];
   logic [2:0]           lvl_mem  [NUM_OPERATORS];
   logic [PW-1:0]        h1_mem   [NUM_OPERATORS];
   logic [PW-1:0]        h2_mem   [NUM_OPERATORS];

   logic                 s1_v, s1_key;
   logic [OP_W-1:0]      s1_op;
   logic [ALG_WIDTH-1:0] s1_alg;
   logic [PW-1:0]        s1_mod;

   logic                 fwd;
   logic [ACC_WIDTH-1:0] rd_acc;
   logic [PW-1:0]        rd_h1, rd_h2;

   logic                 s2_v, s2_key;
   logic [OP_W-1:0]      s2_op;
   logic [ALG_WIDTH-1:0] s2_alg;
   logic [PW-1:0]        s2_mod;
   logic [ACC_WIDTH-1:0] s2_acc, s2_step;
   logic [2:0]           s2_lvl;
   logic [PW-1:0]        s2_h1, s2_h2;

   logic [ACC_WIDTH-1:0] acc_next;
   logic [PW-1:0]        ph;
   logic [3:0]           fb_shift;
   logic signed [PW:0]   h_sum, fb_sh;
   logic [PW:0]          fb;

   logic                 s3_v;
   logic [OP_W-1:0]      s3_op;
   logic [ALG_WIDTH-1:0] s3_alg;
   logic [PW-1:0]        s3_ph, s3_mod;
   logic [PW:0]          s3_fb, sum;

   // sweep state register and clear address counter
   always_ff @(posedge i_Clock or negedge i_Reset_n)
      if (!i_Reset_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_next;
         clr_cnt <= clr_en ? clr_cnt + 1'b1 : '0;
      end

   // leave the sweep once the last operator address has been zeroed
   always_comb state_next = (state == CLEAR && clr_cnt == OP_W'(NUM_OPERATORS - 1)) ? RUN : state;

   // ready and clear strobe decoded from the state
   always_comb begin
      run    = state == RUN;
      clr_en = state == CLEAR;
   end

   assign o_Ready = run;

   // step bytes (MSB first) and feedback level; zeroed by the sweep
   always_ff @(posedge i_Clock)
      if (clr_en) begin
         step_mem[clr_cnt] <= '0;
         lvl_mem[clr_cnt]  <= '0;
      end else if (i_ConfigWriteEnable) begin
         for (int b = 0; b < NB; b++)
            if (i_ConfigWriteSel == 3'(b)) step_mem[i_ConfigWriteAddr][ACC_WIDTH-1-8*b -: 8] <= i_ConfigWriteData;
         if (i_ConfigWriteSel == 3'd7) lvl_mem[i_ConfigWriteAddr] <= i_ConfigWriteData[2:0];
      end

   // accumulator write-back from S2
   always_ff @(posedge i_Clock)
      if (clr_en) acc_mem[clr_cnt] <= '0;
      else if (s2_v) acc_mem[s2_op] <= acc_next;

   // feedback history shift; a key-on clear issued later in this block wins over a same-edge sample
   always_ff @(posedge i_Clock)
      if (clr_en) begin
         h1_mem[clr_cnt] <= '0;
         h2_mem[clr_cnt] <= '0;
      end else begin
         if (i_FeedbackValid) begin
            h1_mem[i_FeedbackOperator] <= i_FeedbackSample;
            h2_mem[i_FeedbackOperator] <= h1_mem[i_FeedbackOperator];
         end
         if (s2_v && s2_key) begin
            h1_mem[s2_op] <= '0;
            h2_mem[s2_op] <= '0;
         end
      end

   // S1: capture the incoming slot; nothing enters while the sweep runs
   always_ff @(posedge i_Clock or negedge i_Reset_n)
      if (!i_Reset_n) begin
         s1_v   <= 1'b0;
         s1_key <= 1'b0;
         s1_op  <= '0;
         s1_alg <= '0;
         s1_mod <= '0;
      end else begin
         s1_v <= run && i_Valid;
         if (run) begin
            s1_key <= i_KeyOn;
            s1_op  <= i_VoiceOperator;
            s1_alg <= i_AlgorithmWord;
            s1_mod <= i_ModulationPhase;
         end
      end

   // S1 read, taking the S2 result directly when both stages hold the same operator
   always_comb begin
      fwd    = s2_v && s2_op == s1_op;
      rd_acc = fwd ? acc_next : acc_mem[s1_op];
      rd_h1  = (fwd && s2_key) ? '0 : h1_mem[s1_op];
      rd_h2  = (fwd && s2_key) ? '0 : h2_mem[s1_op];
   end

   // S2: hold the operator state read in S1
   always_ff @(posedge i_Clock or negedge i_Reset_n)
      if (!i_Reset_n) begin
         s2_v    <= 1'b0;
         s2_key  <= 1'b0;
         s2_op   <= '0;
         s2_alg  <= '0;
         s2_mod  <= '0;
         s2_acc  <= '0;
         s2_step <= '0;
         s2_lvl  <= '0;
         s2_h1   <= '0;
         s2_h2   <= '0;
      end else begin
         s2_v    <= s1_v;
         s2_key  <= s1_key;
         s2_op   <= s1_op;
         s2_alg  <= s1_alg;
         s2_mod  <= s1_mod;
         s2_acc  <= rd_acc;
         s2_step <= step_mem[s1_op];
         s2_lvl  <= lvl_mem[s1_op];
         s2_h1   <= rd_h1;
         s2_h2   <= rd_h2;
      end

   // S2 compute: next accumulator, pre-step phase and scaled self-feedback
   always_comb begin
      acc_next = s2_key ? s2_step : s2_acc + s2_step;
      ph       = s2_key ? '0 : s2_acc[ACC_WIDTH-1 -: PW];
      h_sum    = $signed({s2_h1[PW-1], s2_h1}) + $signed({s2_h2[PW-1], s2_h2});
      fb_shift = 4'd9 - {1'b0, s2_lvl};
      fb_sh    = h_sum >>> fb_shift;
      fb       = (s2_key || s2_lvl == 3'd0) ? '0 : fb_sh;
   end

   // S3: hold phase components for the final sum
   always_ff @(posedge i_Clock or negedge i_Reset_n)
      if (!i_Reset_n) begin
         s3_v   <= 1'b0;
         s3_op  <= '0;
         s3_alg <= '0;
         s3_ph  <= '0;
         s3_mod <= '0;
         s3_fb  <= '0;
      end else begin
         s3_v   <= s2_v;
         s3_op  <= s2_op;
         s3_alg <= s2_alg;
         s3_ph  <= ph;
         s3_mod <= s2_mod;
         s3_fb  <= fb;
      end

   // modulated phase wraps at PHASE_WIDTH+1 bits
   always_comb sum = {1'b0, s3_ph} + {s3_mod[PW-1], s3_mod} + s3_fb;

   // output register; invalid slots carry a zero phase
   always_ff @(posedge i_Clock or negedge i_Reset_n)
      if (!i_Reset_n) begin
         o_Valid          <= 1'b0;
         o_VoiceOperator  <= '0;
         o_AlgorithmWord  <= '0;
         o_ModulatedPhase <= '0;
      end else begin
         o_Valid          <= s3_v;
         o_VoiceOperator  <= s3_op;
         o_AlgorithmWord  <= s3_alg;
         o_ModulatedPhase <= s3_v ? sum : '0;
      end
endmodule
